s2p_load_ctrl: RTL and testbench
================================

Name: s2p_load_ctrl

Overview:
Sequencer for the 8-bit serial-to-parallel output register.
- Accepts a parallel byte over a valid/ready handshake.
- Serializes the byte MSB-first onto the register's serial input, pacing each bit with a shift-enable pulse at a divided rate.
- After the last bit, pulses the storage strobe so the shifted word moves to the output stage, then drives the active-low output enable.
- Sits between the host-side byte source and the shift/storage/OE pins of the register.

Parameters:
- DW, 8, word width; number of serial bits per transfer.
- DIV, 4, system clocks per serial bit; legal range 2..255.
- HOLD, 16, minimum clocks after the strobe before the next byte is accepted; legal range 1..65535.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DW  byte to load.
- in_valid  in  1  in_data valid.
- in_ready  out  1  controller can accept a byte.
- out_en  in  1  host request to drive the register outputs.
- sin  out  1  serial data to the shift register.
- sh_en  out  1  one-cycle shift-enable pulse; the register samples sin on this cycle.
- st_clk  out  1  one-cycle storage strobe.
- oe_n  out  1  output enable, active low.
- busy  out  1  transfer in progress (any state other than IDLE).
- done  out  1  one-cycle pulse on the last HOLD cycle.

Behaviour:
- Clock and reset: single clock, clk. Reset is asynchronous on rst_n, active low. All state flops clear on reset.
- Reset values: state IDLE, sin 0, sh_en 0, st_clk 0, oe_n 1, busy 0, done 0. Internal flag loaded=0, div_cnt=0, bit_cnt=0.
- in_ready is 1 exactly when state is IDLE, including the first cycle after reset release.
- Handshake: a transfer is accepted on a cycle where in_valid and in_ready are both 1 (call it cycle 0).
  - in_data is captured into the shift shadow register.
  - bit_cnt is set to DW-1, div_cnt to 0, and the state moves to SHIFT.
  - in_valid while not IDLE is ignored and no data is captured. The source must hold the byte until it is accepted.
- SHIFT state:
  - sin always equals the shadow register MSB.
  - div_cnt increments every clock and wraps at DIV-1.
  - On a cycle with div_cnt==DIV-1: sh_en=1, the shadow register shifts left by 1 (zero fill), and bit_cnt decrements.
  - If bit_cnt==0 on that pulse, the state moves to LATCH.
  - sh_en pulses fall on cycles DIV, 2*DIV, ..., DW*DIV after acceptance. sin is stable for DIV cycles around each pulse.
- LATCH state: lasts one cycle. st_clk=1, loaded is set to 1, and the state moves to HOLD. This is cycle DW*DIV+1.
- HOLD state:
  - Lasts exactly HOLD cycles (cycles DW*DIV+2 through DW*DIV+1+HOLD).
  - done=1 on the final HOLD cycle; the state then moves to IDLE.
- oe_n = ~(out_en & loaded), registered, so it follows out_en with a 1-cycle delay.
  - oe_n is 1 until the first completed strobe after reset.
- Timing:
  - Latency from acceptance to st_clk is DW*DIV+1 cycles.
  - Acceptance to the next in_ready is DW*DIV+2+HOLD cycles.
  - With defaults: 33 cycles to strobe, next accept possible at cycle 50.
- Back-to-back: in_valid held high is accepted on the first IDLE cycle. The gap between transfers is exactly 0 idle cycles beyond HOLD.
- Width rules: div_cnt is $clog2(DIV) bits, bit_cnt is $clog2(DW) bits, and the HOLD counter is 16 bits.
- Reset mid-operation: the transfer is aborted immediately.
  - sh_en and st_clk drop and oe_n goes high; loaded is cleared.
  - No partial strobe is ever issued.
- sh_en and st_clk are never high on the same cycle. done and in_ready are never high on the same cycle.

Optional Feature:
Macro S2P_LOAD_CTRL_BLANK_EN.
- Defined: oe_n is forced to 1 while the state is SHIFT or LATCH, so outputs are blanked during reload. Normal oe_n resumes in the first HOLD cycle.
- Undefined: oe_n depends only on out_en and loaded. Outputs keep showing the previous word during shifting, because the storage stage isolates them.

Test Plan:
- Reset, then out_en=1 with no transfer -> oe_n stays 1 (loaded=0), in_ready=1, and sh_en, st_clk and done all stay 0.
- in_data=8'hA5 accepted at cycle 0 with DIV=4 -> sh_en at cycles 4,8,...,32; sin on those cycles reads 1,0,1,0,0,1,0,1; st_clk at 33; done at 49; in_ready at 50.
- Same transfer with out_en=1 -> oe_n goes to 0 at cycle 35 and stays 0. With BLANK_EN, a second transfer drives oe_n to 1 during its SHIFT/LATCH and back to 0 in HOLD.
- in_valid held high with 8'h01 then 8'hFF queued -> second acceptance exactly at cycle 50; second strobe at 83; the 8 sampled sin bits equal 8'hFF.
- Assert rst_n=0 at cycle 17 of a transfer -> immediately oe_n=1 and sh_en=0, with no st_clk. After release, in_ready=1 and a new byte 8'h3C completes normally.
- in_valid pulsed during SHIFT with a different byte -> ignored; the sampled word equals the original byte and only one st_clk is issued.

Source files
------------

// File: rtl/s2p_load_ctrl_if.sv
// Host-side byte handshake plus shift/storage/OE pin bundle for the 8-bit
// serial-to-parallel output register sequencer.
interface s2p_load_ctrl_if #(
  parameter int DW = 8
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          out_en;
  logic          sin;
  logic          sh_en;
  logic          st_clk;
  logic          oe_n;
  logic          busy;
  logic          done;

  modport master (
    output in_data, in_valid, out_en,
    input  in_ready, sin, sh_en, st_clk, oe_n, busy, done
  );

  modport slave (
    input  in_data, in_valid, out_en,
    output in_ready, sin, sh_en, st_clk, oe_n, busy, done
  );
endinterface

// File: rtl/s2p_load_ctrl.sv
// Serializes a byte MSB-first into a shift/storage register, strobes it to the
// output stage, then holds off for HOLD clocks. Option: S2P_LOAD_CTRL_BLANK_EN.
//
// state   | meaning
// S_IDLE  | ready for a byte (in_ready=1)
// S_SHIFT | clocking bits out, one sh_en pulse every DIV clocks
// S_LATCH | one-cycle storage strobe
// S_HOLD  | HOLD-cycle settle window, done on the last cycle
module s2p_load_ctrl #(
  parameter int DW   = 8,
  parameter int DIV  = 4,
  parameter int HOLD = 16
) (
  input logic            clk,
  input logic            rst_n,
  s2p_load_ctrl_if.slave bus
);
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BCW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [DCW-1:0] DIV_PRE  = DCW'(DIV - 2);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_HOLD} state_t;

  state_t        state;
  logic [DW-1:0] shadow;
  logic [DCW-1:0] div_cnt;
  logic [BCW-1:0] bit_cnt;
  logic [15:0]   hold_cnt;
  logic          loaded;
  logic          sh_en_q, st_clk_q, done_q, oe_n_q;

`ifdef S2P_LOAD_CTRL_BLANK_EN
  logic blank;
  // Blank from the acceptance edge through the last SHIFT cycle, so oe_n is
  // forced high for all of SHIFT and LATCH and returns in the first HOLD cycle.
  always_comb begin
    blank = 1'b0;
    if ((state == S_IDLE && bus.in_valid) || state == S_SHIFT) blank = 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      shadow   <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      hold_cnt <= '0;
      loaded   <= 1'b0;
      sh_en_q  <= 1'b0;
      st_clk_q <= 1'b0;
      done_q   <= 1'b0;
      oe_n_q   <= 1'b1;
    end else begin
      sh_en_q  <= 1'b0;
      st_clk_q <= 1'b0;
      done_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            shadow  <= bus.in_data;
            bit_cnt <= BCW'(DW - 1);
            div_cnt <= '0;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
          // Registered pulse is armed one count early so it lands on DIV_LAST.
          if (div_cnt == DIV_PRE) sh_en_q <= 1'b1;
          if (div_cnt == DIV_LAST) begin
            shadow  <= {shadow[DW-2:0], 1'b0};
            bit_cnt <= bit_cnt - 1'b1;
            if (bit_cnt == '0) begin
              state    <= S_LATCH;
              st_clk_q <= 1'b1;
            end
          end
        end
        S_LATCH: begin
          loaded   <= 1'b1;
          hold_cnt <= 16'(HOLD - 1);
          done_q   <= (HOLD == 1);
          state    <= S_HOLD;
        end
        S_HOLD: begin
          done_q <= (hold_cnt == 16'd1);
          if (hold_cnt == '0) state <= S_IDLE;
          else                hold_cnt <= hold_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
`ifdef S2P_LOAD_CTRL_BLANK_EN
      oe_n_q <= blank ? 1'b1 : ~(bus.out_en & loaded);
`else
      oe_n_q <= ~(bus.out_en & loaded);
`endif
    end
  end

  assign bus.in_ready = (state == S_IDLE);
  assign bus.busy     = (state != S_IDLE);
  assign bus.sin      = shadow[DW-1];
  assign bus.sh_en    = sh_en_q;
  assign bus.st_clk   = st_clk_q;
  assign bus.done     = done_q;
  assign bus.oe_n     = oe_n_q;
endmodule

// File: tb/tb_s2p_load_ctrl.sv
// Directed bench for s2p_load_ctrl: timing of sh_en/st_clk/done/in_ready,
// sampled serial word, oe_n behaviour, mid-transfer reset and ignored in_valid.
module tb_s2p_load_ctrl;
  localparam int DW = 8, DIV = 4, HOLD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  s2p_load_ctrl_if #(.DW(DW)) bus ();

  s2p_load_ctrl #(.DW(DW), .DIV(DIV), .HOLD(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  int acc_cyc = 0, acc_prev = 0, tot_acc = 0;
  int tot_sh = 0, tot_st = 0, tot_done = 0, viol = 0, oe0 = -1;
  logic [7:0] word = '0, prev_word = '0;
  int sh_q[$], st_q[$], done_q[$];

  // Event recorder: cycle offsets are relative to the most recent acceptance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) begin
        prev_word = word; acc_prev = acc_cyc; acc_cyc = cyc; tot_acc++;
        word = '0; oe0 = -1;
        sh_q.delete(); st_q.delete(); done_q.delete();
      end
      if (bus.sh_en)  begin sh_q.push_back(cyc - acc_cyc); word = {word[6:0], bus.sin}; tot_sh++; end
      if (bus.st_clk) begin st_q.push_back(cyc - acc_cyc); tot_st++; end
      if (bus.done)   begin done_q.push_back(cyc - acc_cyc); tot_done++; end
      if (!bus.oe_n && oe0 < 0) oe0 = cyc - acc_cyc;
      if ((bus.sh_en && bus.st_clk) || (bus.done && bus.in_ready)) viol++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  task automatic timeout(input string tag);
    tests++; fails++;
    $display("FAIL %s timeout observed=none expected=event", tag);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit keep_valid);
    int n = 0;
    @(negedge clk); bus.in_valid = 1'b1; bus.in_data = b;
    while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timeout("accept");
    @(posedge clk); #1;
    if (!keep_valid) bus.in_valid = 1'b0;
  endtask

  task automatic wait_ready(output int rel);
    int n = 0;
    @(negedge clk); #1;
    while (!bus.in_ready && n < 300) begin @(negedge clk); #1; n++; end
    if (n >= 300) timeout("ready");
    rel = cyc - acc_cyc;
  endtask

  task automatic wait_rel(input int target);
    int n = 0;
    @(negedge clk); #1;
    while ((cyc - acc_cyc) != target && n < 300) begin @(negedge clk); #1; n++; end
    if (n >= 300) timeout("wait_rel");
  endtask

  initial begin
    int rel, acc_before;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_en = 1'b0;

    // 1: idle after reset with out_en requested
    do_reset();
    bus.out_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_oe_n", bus.oe_n, 1);
    chk("idle_in_ready", bus.in_ready, 1);
    chk("idle_busy", bus.busy, 0);
    chk("idle_sh_en_count", tot_sh, 0);
    chk("idle_st_count", tot_st, 0);
    chk("idle_done_count", tot_done, 0);

    // 2: A5 timing with outputs disabled
    do_reset();
    bus.out_en = 1'b0;
    send(8'hA5, 1'b0);
    chk("a5_busy", bus.busy, 1);
    wait_ready(rel);
    chk("a5_ready_cycle", rel, 50);
    chk("a5_sh_count", sh_q.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("a5_sh_cycle%0d", i), qget(sh_q, i), (i + 1) * DIV);
    chk("a5_word", word, 8'hA5);
    chk("a5_st_count", st_q.size(), 1);
    chk("a5_st_cycle", qget(st_q, 0), 33);
    chk("a5_done_cycle", qget(done_q, 0), 49);
    chk("a5_oe_n_off", bus.oe_n, 1);

    // 3: same transfer with out_en, fresh from reset
    do_reset();
    bus.out_en = 1'b1;
    send(8'hA5, 1'b0);
    wait_ready(rel);
    chk("oe_first_low_cycle", oe0, 35);
    chk("oe_n_after", bus.oe_n, 0);

    // 4: back-to-back with in_valid held
    do_reset();
    send(8'h01, 1'b1);
    bus.in_data = 8'hFF;
    wait_ready(rel);
    @(posedge clk); #1; bus.in_valid = 1'b0;
    chk("b2b_gap", acc_cyc - acc_prev, 50);
    chk("b2b_first_word", prev_word, 8'h01);
    wait_ready(rel);
    chk("b2b_second_word", word, 8'hFF);
    chk("b2b_second_st", qget(st_q, 0), 33);
    chk("b2b_second_sh_count", sh_q.size(), 8);

    // 5: reset at cycle 17 of a transfer
    chk("pre_abort_oe_n", bus.oe_n, 0);
    send(8'h96, 1'b0);
    wait_rel(17);
    rst_n = 1'b0;
    #1;
    chk("abort_oe_n", bus.oe_n, 1);
    chk("abort_sh_en", bus.sh_en, 0);
    chk("abort_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    chk("abort_no_strobe", st_q.size(), 0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("abort_in_ready", bus.in_ready, 1);
    send(8'h3C, 1'b0);
    wait_ready(rel);
    chk("post_abort_word", word, 8'h3C);
    chk("post_abort_st", qget(st_q, 0), 33);
    chk("post_abort_done", qget(done_q, 0), 49);

    // 6: in_valid pulsed mid-shift is ignored
    acc_before = tot_acc;
    send(8'hC3, 1'b0);
    wait_rel(10);
    bus.in_valid = 1'b1; bus.in_data = 8'h5A;
`ifdef S2P_LOAD_CTRL_BLANK_EN
    chk("shift_oe_n_blank", bus.oe_n, 1);
`else
    chk("shift_oe_n", bus.oe_n, 0);
`endif
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    wait_rel(34);
    chk("hold_oe_n", bus.oe_n, 0);
    wait_ready(rel);
    chk("ignore_word", word, 8'hC3);
    chk("ignore_st_count", st_q.size(), 1);
    chk("ignore_accepts", tot_acc - acc_before, 1);

    chk("exclusive_pulses", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end
endmodule
